seg_display_arbiter: RTL

Round-robin scheduler that shares the board's single 7-segment display (`SEG`) among up to `NREQ` requesters, for example grade display, pass/fail situation and error indication. Each requester raises `req` and drives its own 8-bit segment pattern. The arbiter grants the display to one owner at a time for a fixed dwell period and inserts a one-cycle blank between owners. The arbiter sits between the display-pattern generators and the top-level `SEG`/`LED` outputs.

---
 rtl/seg_display_arbiter_if.sv | 18 +
 rtl/seg_display_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/seg_display_arbiter_if.sv
// Display-share bus: requester levels and patterns in, the granted pattern and arbitration status out.
// The arbiter connects through the slave modport and the pattern generators or bench through the master modport.
interface seg_display_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int SEG_W = 8
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*SEG_W-1:0] seg_in;
    logic [SEG_W-1:0]      SEG;
    logic [NREQ-1:0]       grant;
    logic [OW-1:0]         owner;
    logic                  busy;

    modport master (output req, seg_in, input SEG, grant, owner, busy);
    modport slave  (input req, seg_in, output SEG, grant, owner, busy);
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 7-segment display: DWELL cycles per turn under contention, one blank cycle between owners.
// One cycle from req to grant and from seg_in to SEG. Requesters hold req as a level; there is no backpressure.
module seg_display_arbiter #(
    parameter int NREQ  = 4,
    parameter int SEG_W = 8,
    parameter int DWELL = 8
) (
    input  logic                 clk_2,
    input  logic                 rst_n,
    seg_display_arbiter_if.slave bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} state_t;

    state_t           r_state, w_state_nxt;
    logic [OW-1:0]    r_owner, w_owner_nxt, w_pick;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [SEG_W-1:0] r_seg, w_seg_nxt;
    logic [NREQ-1:0]  r_grant, w_grant_nxt;
    logic             r_busy;
    logic [NREQ-1:0]  w_owner_oh, w_others;

    assign w_owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_others   = bus.req & ~w_owner_oh;

    // Scan downwards so the nearest requester after r_owner is the last to overwrite w_pick.
    always_comb begin
        w_pick = r_owner;
        for (int i = NREQ; i >= 1; i--) begin
            if (bus.req[(int'(r_owner) + i) % NREQ]) begin
                w_pick = OW'((int'(r_owner) + i) % NREQ);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_SHOW: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
                if (!bus.req[r_owner]) begin
                    w_state_nxt = (|w_others) ? ST_GAP : ST_IDLE;
                end else if (r_cnt == '0) begin
                    if (|w_others) begin
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_cnt_nxt = CW'(DWELL - 1);
                    end
                end
            end
            default: begin
                if (|bus.req) begin
                    w_state_nxt = ST_SHOW;
                    w_owner_nxt = w_pick;
                    w_cnt_nxt   = CW'(DWELL - 1);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Outputs are derived from the next state so every output moves on the same edge.
    always_comb begin
        w_seg_nxt   = '0;
        w_grant_nxt = '0;
        if (w_state_nxt == ST_SHOW) begin
            w_seg_nxt   = bus.seg_in[w_owner_nxt*SEG_W +: SEG_W];
            w_grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << w_owner_nxt;
        end
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= OW'(NREQ - 1);
            r_cnt   <= '0;
            r_seg   <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_seg   <= w_seg_nxt;
            r_grant <= w_grant_nxt;
            r_busy  <= (w_state_nxt == ST_SHOW);
        end
    end

    assign bus.SEG   = r_seg;
    assign bus.grant = r_grant;
    assign bus.owner = r_owner;
    assign bus.busy  = r_busy;
endmodule
